// File: rtl/vehicle_sensor_conditioner.sv
// Loop-detector conditioning for the two-road traffic light controller.
// Each road gets a 2-flop synchronizer, debounce on assertion, hold-off on release and a stuck-detector fault.

module vsc_channel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int STUCK_CYCLES    = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic sensor_o,
    output logic fault_o
);
    localparam int MAX_DH = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_C  = (MAX_DH > STUCK_CYCLES) ? MAX_DH : STUCK_CYCLES;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] ONE        = CW'(1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STUCK_LAST = CW'(STUCK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        QUAL    = 3'd1,
        PRESENT = 3'd2,
        HOLD    = 3'd3,
        FAULT   = 3'd4
    } state_e;

    logic          sync1_q, sync2_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] scnt_q, scnt_d;
    logic          sensor_q, fault_q;

    // NOTE: every clocked register uses <= so all flops sample pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        scnt_d  = scnt_q;
        unique case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = QUAL;
                    cnt_d   = ONE;
                end
            end
            QUAL: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = PRESENT;
                    scnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            PRESENT: begin
                if (!sync2_q) begin
                    state_d = HOLD;
                    cnt_d   = ONE;
                end else if (scnt_q == STUCK_LAST) begin
                    state_d = FAULT;
                    cnt_d   = '0;
                end else begin
                    scnt_d = scnt_q + ONE;
                end
            end
            HOLD: begin
                if (sync2_q) begin
                    state_d = PRESENT;
                    scnt_d  = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            FAULT: begin
                if (sync2_q) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                scnt_d  = '0;
            end
        endcase
    end

    // Outputs decode the next state so they change on the same edge as the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            scnt_q   <= '0;
            sensor_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            scnt_q   <= scnt_d;
            sensor_q <= (state_d == PRESENT) || (state_d == HOLD) || (state_d == FAULT);
            fault_q  <= (state_d == FAULT);
        end
    end

    assign sensor_o = sensor_q;
    assign fault_o  = fault_q;
endmodule

module vehicle_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int STUCK_CYCLES    = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rawA,
    input  logic rawB,
    output logic sensorA,
    output logic sensorB,
    output logic faultA,
    output logic faultB
);
    vsc_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .STUCK_CYCLES   (STUCK_CYCLES)
    ) u_chan_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_i   (rawA),
        .sensor_o(sensorA),
        .fault_o (faultA)
    );

    vsc_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .STUCK_CYCLES   (STUCK_CYCLES)
    ) u_chan_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_i   (rawB),
        .sensor_o(sensorB),
        .fault_o (faultB)
    );
endmodule

// File: doc/vehicle_sensor_conditioner.md
Name: vehicle_sensor_conditioner

Overview:
Upstream stage of the two-road traffic light controller. Conditions the raw loop-detector inputs for roads A and B and produces the clean, registered `sensorA`/`sensorB` demand levels that the controller's FSM consumes. Each channel is independent and provides:
- 2-flop synchronization
- counter-based debounce on assertion
- a hold-off (extension) on release
- a stuck-detector fault that keeps demand asserted while the detector is judged faulty

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronized-high samples needed to assert demand; also the consecutive low samples needed to leave FAULT. Must be >= 2.
- HOLD_CYCLES, 8: consecutive synchronized-low samples needed to drop demand. Must be >= 2.
- STUCK_CYCLES, 64: consecutive high samples in PRESENT that declare a stuck detector. Must be >= 2.
- Internal counter width (local, not overridable): clog2(max(DEBOUNCE_CYCLES, HOLD_CYCLES, STUCK_CYCLES) + 1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- rawA  in  1  asynchronous raw detector, road A
- rawB  in  1  asynchronous raw detector, road B
- sensorA  out  1  conditioned demand, road A (registered)
- sensorB  out  1  conditioned demand, road B (registered)
- faultA  out  1  stuck-detector flag, road A (registered)
- faultB  out  1  stuck-detector flag, road B (registered)

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous, active-low. While `rst_n` = 0:
  - all sync flops, counters and FSMs clear immediately
  - sensorA, sensorB, faultA and faultB are all 0
  - both FSMs are in IDLE
- Reset mid-operation aborts any state, with no clock needed. After release, a still-high raw input must re-qualify from scratch.
- Synchronizer: raw passes through 2 flops to give s. The FSM samples s on every rising edge.
- Per-channel FSM has a 1 state counter `cnt` and a stuck counter `scnt`. Output decode:
  - sensor = 1 in PRESENT, HOLD and FAULT.
  - fault = 1 only in FAULT.
- IDLE:
  - s = 1: go to QUAL, cnt = 1.
  - s = 0: stay in IDLE.
- QUAL:
  - s = 0: go to IDLE (glitch rejected).
  - s = 1 and cnt == DEBOUNCE_CYCLES-1: go to PRESENT, scnt = 0.
  - s = 1 otherwise: cnt += 1.
- PRESENT:
  - s = 0: go to HOLD, cnt = 1.
  - s = 1 and scnt == STUCK_CYCLES-1: go to FAULT, cnt = 0.
  - s = 1 otherwise: scnt += 1.
- HOLD:
  - s = 1: go to PRESENT, scnt = 0 (the hold restarts on the next release).
  - s = 0 and cnt == HOLD_CYCLES-1: go to IDLE.
  - s = 0 otherwise: cnt += 1.
- FAULT:
  - s = 1: cnt = 0.
  - s = 0 and cnt == DEBOUNCE_CYCLES-1: go to IDLE (sensor and fault both drop, no hold).
  - s = 0 otherwise: cnt += 1.
- Latency:
  - Raw high first sampled at edge N and held: sensor rises after edge N+DEBOUNCE_CYCLES+1.
  - Raw low first sampled at edge N and held: sensor falls after edge N+HOLD_CYCLES+1.
- Counters never wrap. Every compare is an equality test against a terminal value, and each counter is reloaded on every state entry.
- Channels A and B share no state. Simultaneous events on both channels are handled independently, in the same cycle.
- sensorX and faultX change only on clock edges, or asynchronously to 0 on reset.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, STUCK_CYCLES=64):
1. Assertion: rawA = 1 from edge 10, held -> sensorA = 0 through edge 14, sensorA = 1 after edge 15; sensorB, faultA and faultB stay 0.
2. Glitch rejection: rawA = 1 for edges 10-12 only (3 samples), then 0 -> sensorA never asserts; FSM returns to IDLE.
3. Release and re-press: sensorA high, rawA = 0 from edge 40 -> sensorA falls after edge 49. Repeat with rawA pulsed high for one sample at edge 44 -> the hold restarts, so sensorA falls after edge 54 (low again from edge 45).
4. Stuck detector: rawB = 1 from edge 0 -> sensorB = 1 after edge 5, faultB = 1 after edge 69. Then rawB = 0 from edge 100 -> sensorB = 0 and faultB = 0 after edge 105.
5. Async reset: sensorA = 1 in PRESENT with rawA still high; rst_n = 0 mid-cycle -> sensorA = 0 immediately, without a clock. rst_n released at edge 200 (rawA still high) -> sensorA = 1 only after the full re-qualification, by edge 206.
6. Independence: rawA and rawB rise on the same edge 10 -> both sensors rise after edge 15. rawB then drops at edge 30 -> sensorB falls after edge 39 while sensorA remains 1.
